// File: rtl/ram_dp_rw_ctrl.sv
// Dual-port byte-enabled RAM controller.
// Two independent read and write ports share one memory array. After reset an
// init sequence writes InitValue to every word, one word per cycle, while all
// user accesses are ignored. Read data is registered once (or twice when
// Pipelined is set). Same-address dual writes merge per byte lane, with port A
// taking priority on overlapping lanes. Same-address read/write returns old or
// forwarded data depending on CollisionMode.
module ram_dp_rw_ctrl #(
  parameter int unsigned          AddrWidth     = 6,
  parameter int unsigned          DataWidth     = 32,
  parameter int unsigned          ByteWidth     = 8,
  parameter bit                   Pipelined     = 1'b0,
  parameter bit                   CollisionMode = 1'b0,
  parameter logic [DataWidth-1:0] InitValue     = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rd_en_a_i,
  input  logic                           rd_en_b_i,
  input  logic                           wr_en_a_i,
  input  logic                           wr_en_b_i,
  input  logic [DataWidth/ByteWidth-1:0] be_a_i,
  input  logic [DataWidth/ByteWidth-1:0] be_b_i,
  input  logic [AddrWidth-1:0]           addr_r_a_i,
  input  logic [AddrWidth-1:0]           addr_r_b_i,
  input  logic [AddrWidth-1:0]           addr_w_a_i,
  input  logic [AddrWidth-1:0]           addr_w_b_i,
  input  logic [DataWidth-1:0]           data_a_i,
  input  logic [DataWidth-1:0]           data_b_i,
  output logic [DataWidth-1:0]           data_a_o,
  output logic [DataWidth-1:0]           data_b_o,
  output logic                           valid_a_o,
  output logic                           valid_b_o,
  output logic                           init_busy_o,
  output logic                           wr_conflict_o
);

  localparam int unsigned NB    = DataWidth / ByteWidth;
  localparam int unsigned Depth = 2 ** AddrWidth;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                 state_r;
  logic [AddrWidth-1:0]   init_cnt_r;
  logic                   init_busy_r;
  logic                   wr_conflict_r;
  logic [DataWidth-1:0]   mem_r [Depth];

  logic                   active_s;
  logic                   init_we_s;
  logic                   wr_a_s;
  logic                   wr_b_s;
  logic                   rd_a_s;
  logic                   rd_b_s;
  logic                   same_w_s;
  logic                   conflict_s;
  logic [DataWidth-1:0]   mask_a_s;
  logic [DataWidth-1:0]   mask_b_s;
  logic [DataWidth-1:0]   word_a_s;
  logic [DataWidth-1:0]   word_b_s;
  logic [DataWidth-1:0]   rdata_a_s;
  logic [DataWidth-1:0]   rdata_b_s;

  logic                   s1_valid_a_r;
  logic                   s1_valid_b_r;
  logic [DataWidth-1:0]   s1_data_a_r;
  logic [DataWidth-1:0]   s1_data_b_r;

  // Expand per-lane byte enables into a full-width bit mask.
  function automatic logic [DataWidth-1:0] lane_mask(input logic [NB-1:0] be);
    logic [DataWidth-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      m[i*ByteWidth +: ByteWidth] = {ByteWidth{be[i]}};
    end
    return m;
  endfunction

  // Replace the masked bits of a stored word with new data.
  function automatic logic [DataWidth-1:0] merge_word(
    input logic [DataWidth-1:0] old_word,
    input logic [DataWidth-1:0] new_word,
    input logic [DataWidth-1:0] mask
  );
    return (old_word & ~mask) | (new_word & mask);
  endfunction

  // Pick the value a read returns: stored word, or the word being written this
  // cycle when forwarding is enabled. Port A's word already carries B's lanes
  // when both ports target the same address.
  function automatic logic [DataWidth-1:0] read_word(
    input logic [DataWidth-1:0] stored,
    input logic                 hit_a,
    input logic [DataWidth-1:0] wa,
    input logic                 hit_b,
    input logic [DataWidth-1:0] wb
  );
    logic [DataWidth-1:0] r;
    if (CollisionMode && hit_a) begin
      r = wa;
    end else if (CollisionMode && hit_b) begin
      r = wb;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  // Access qualification and next-word computation for both write ports.
  always_comb begin
    active_s   = (state_r == ST_READY) && !rst_i;
    init_we_s  = (state_r == ST_INIT) && !rst_i;
    wr_a_s     = active_s && wr_en_a_i;
    wr_b_s     = active_s && wr_en_b_i;
    rd_a_s     = active_s && rd_en_a_i;
    rd_b_s     = active_s && rd_en_b_i;
    same_w_s   = (addr_w_a_i == addr_w_b_i);
    mask_a_s   = lane_mask(be_a_i);
    mask_b_s   = lane_mask(be_b_i);
    word_b_s   = merge_word(mem_r[addr_w_b_i], data_b_i, mask_b_s);
    if (wr_b_s && same_w_s) begin
      word_a_s = merge_word(word_b_s, data_a_i, mask_a_s);
    end else begin
      word_a_s = merge_word(mem_r[addr_w_a_i], data_a_i, mask_a_s);
    end
    conflict_s = wr_a_s && wr_b_s && same_w_s && (|(be_a_i & be_b_i));
  end

  // Read data selection with optional write-first forwarding.
  always_comb begin
    rdata_a_s = read_word(mem_r[addr_r_a_i],
                          wr_a_s && (addr_w_a_i == addr_r_a_i), word_a_s,
                          wr_b_s && (addr_w_b_i == addr_r_a_i), word_b_s);
    rdata_b_s = read_word(mem_r[addr_r_b_i],
                          wr_a_s && (addr_w_a_i == addr_r_b_i), word_a_s,
                          wr_b_s && (addr_w_b_i == addr_r_b_i), word_b_s);
  end

  // Init/ready state machine with registered busy and conflict flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_INIT;
      init_cnt_r    <= '0;
      init_busy_r   <= 1'b1;
      wr_conflict_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_cnt_r    <= init_cnt_r + AddrWidth'(1);
          wr_conflict_r <= 1'b0;
          if (init_cnt_r == '1) begin
            state_r     <= ST_READY;
            init_busy_r <= 1'b0;
          end else begin
            init_busy_r <= 1'b1;
          end
        end
        ST_READY: begin
          init_busy_r   <= 1'b0;
          wr_conflict_r <= conflict_s;
        end
        default: begin
          state_r       <= ST_INIT;
          init_cnt_r    <= '0;
          init_busy_r   <= 1'b1;
          wr_conflict_r <= 1'b0;
        end
      endcase
    end
  end

  // Memory array: init fill, then user writes (A written last so it wins).
  always_ff @(posedge clk_i) begin
    if (init_we_s) begin
      mem_r[init_cnt_r] <= InitValue;
    end else begin
      if (wr_b_s) begin
        mem_r[addr_w_b_i] <= word_b_s;
      end
      if (wr_a_s) begin
        mem_r[addr_w_a_i] <= word_a_s;
      end
    end
  end

  // First read stage: data only moves on an accepted read, so it holds otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_a_r <= 1'b0;
      s1_valid_b_r <= 1'b0;
      s1_data_a_r  <= '0;
      s1_data_b_r  <= '0;
    end else begin
      s1_valid_a_r <= rd_a_s;
      s1_valid_b_r <= rd_b_s;
      if (rd_a_s) begin
        s1_data_a_r <= rdata_a_s;
      end
      if (rd_b_s) begin
        s1_data_b_r <= rdata_b_s;
      end
    end
  end

  if (Pipelined) begin : g_pipe
    logic                 s2_valid_a_r;
    logic                 s2_valid_b_r;
    logic [DataWidth-1:0] s2_data_a_r;
    logic [DataWidth-1:0] s2_data_b_r;

    // Second read stage: data and valid advance together, no bubbles.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s2_valid_a_r <= 1'b0;
        s2_valid_b_r <= 1'b0;
        s2_data_a_r  <= '0;
        s2_data_b_r  <= '0;
      end else begin
        s2_valid_a_r <= s1_valid_a_r;
        s2_valid_b_r <= s1_valid_b_r;
        if (s1_valid_a_r) begin
          s2_data_a_r <= s1_data_a_r;
        end
        if (s1_valid_b_r) begin
          s2_data_b_r <= s1_data_b_r;
        end
      end
    end

    assign data_a_o  = s2_data_a_r;
    assign data_b_o  = s2_data_b_r;
    assign valid_a_o = s2_valid_a_r;
    assign valid_b_o = s2_valid_b_r;
  end else begin : g_flat
    assign data_a_o  = s1_data_a_r;
    assign data_b_o  = s1_data_b_r;
    assign valid_a_o = s1_valid_a_r;
    assign valid_b_o = s1_valid_b_r;
  end

  assign init_busy_o   = init_busy_r;
  assign wr_conflict_o = wr_conflict_r;

endmodule

// File: tb/tb_ram_dp_rw_ctrl.sv
// Scoreboard bench for ram_dp_rw_ctrl. Two instances share all inputs:
// u0 = latency 1 / old-data collisions, u1 = latency 2 / forwarded collisions.
// Stimulus pushes expected read words (with due cycle) and conflict pulses into
// queues; a negedge monitor pops and compares whenever the DUTs present output.
module tb_ram_dp_rw_ctrl;

  localparam logic [31:0] IV = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en_a = 1'b0, rd_en_b = 1'b0, wr_en_a = 1'b0, wr_en_b = 1'b0;
  logic [3:0]  be_a = 4'h0, be_b = 4'h0;
  logic [3:0]  addr_r_a = 4'h0, addr_r_b = 4'h0, addr_w_a = 4'h0, addr_w_b = 4'h0;
  logic [31:0] data_a = 32'h0, data_b = 32'h0;

  logic [31:0] d_a0, d_b0, d_a1, d_b1;
  logic        v_a0, v_b0, v_a1, v_b1;
  logic        busy0, busy1, conf0, conf1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q [4][$];
  int          qc [2][$];
  logic [31:0] last_d [4];
  string       names [4] = '{"u0_a", "u0_b", "u1_a", "u1_b"};
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          hold_en = 1'b0;

  ram_dp_rw_ctrl #(
    .AddrWidth(4), .DataWidth(32), .ByteWidth(8),
    .Pipelined(1'b0), .CollisionMode(1'b0), .InitValue(IV)
  ) u0 (
    .clk_i(clk), .rst_i(rst),
    .rd_en_a_i(rd_en_a), .rd_en_b_i(rd_en_b), .wr_en_a_i(wr_en_a), .wr_en_b_i(wr_en_b),
    .be_a_i(be_a), .be_b_i(be_b),
    .addr_r_a_i(addr_r_a), .addr_r_b_i(addr_r_b), .addr_w_a_i(addr_w_a), .addr_w_b_i(addr_w_b),
    .data_a_i(data_a), .data_b_i(data_b),
    .data_a_o(d_a0), .data_b_o(d_b0), .valid_a_o(v_a0), .valid_b_o(v_b0),
    .init_busy_o(busy0), .wr_conflict_o(conf0)
  );

  ram_dp_rw_ctrl #(
    .AddrWidth(4), .DataWidth(32), .ByteWidth(8),
    .Pipelined(1'b1), .CollisionMode(1'b1), .InitValue(IV)
  ) u1 (
    .clk_i(clk), .rst_i(rst),
    .rd_en_a_i(rd_en_a), .rd_en_b_i(rd_en_b), .wr_en_a_i(wr_en_a), .wr_en_b_i(wr_en_b),
    .be_a_i(be_a), .be_b_i(be_b),
    .addr_r_a_i(addr_r_a), .addr_r_b_i(addr_r_b), .addr_w_a_i(addr_w_a), .addr_w_b_i(addr_w_b),
    .data_a_i(data_a), .data_b_i(data_b),
    .data_a_o(d_a1), .data_b_o(d_b1), .valid_a_o(v_a1), .valid_b_o(v_b1),
    .init_busy_o(busy1), .wr_conflict_o(conf1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  task automatic mon_port(input int i, input logic v, input logic [31:0] d);
    exp_t e;
    if (v === 1'b1) begin
      checks++;
      if (q[i].size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid %s cyc=%0d got=%h", names[i], cyc, d);
      end else begin
        e = q[i].pop_front();
        if (d !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL rd_data %s cyc=%0d got=%h required=%h due_cyc=%0d", names[i], cyc, d, e.data, e.due);
        end
        last_d[i] = e.data;
      end
    end else begin
      if (q[i].size() > 0 && q[i][0].due <= cyc) begin
        checks++;
        errors++;
        e = q[i].pop_front();
        $display("FAIL missing_valid %s cyc=%0d valid=%b required_data=%h", names[i], cyc, v, e.data);
      end
      if (hold_en) begin
        checks++;
        if (d !== last_d[i]) begin
          errors++;
          $display("FAIL hold %s cyc=%0d got=%h required=%h", names[i], cyc, d, last_d[i]);
        end
      end
    end
  endtask

  task automatic mon_conf(input int i, input logic c);
    int due;
    if (c === 1'b1) begin
      checks++;
      if (qc[i].size() == 0) begin
        errors++;
        $display("FAIL unexpected_conflict u%0d cyc=%0d got=1 required=0", i, cyc);
      end else begin
        due = qc[i].pop_front();
        if (due != cyc) begin
          errors++;
          $display("FAIL conflict_time u%0d cyc=%0d required_cyc=%0d", i, cyc, due);
        end
      end
    end else if (qc[i].size() > 0 && qc[i][0] <= cyc) begin
      checks++;
      errors++;
      due = qc[i].pop_front();
      $display("FAIL missing_conflict u%0d cyc=%0d got=%b required=1", i, cyc, c);
    end
  endtask

  always @(negedge clk) begin
    mon_port(0, v_a0, d_a0);
    mon_port(1, v_b0, d_b0);
    mon_port(2, v_a1, d_a1);
    mon_port(3, v_b1, d_b1);
    mon_conf(0, conf0);
    mon_conf(1, conf1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, req);
    end
  endtask

  task automatic idle();
    rd_en_a = 1'b0; rd_en_b = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0;
    be_a = 4'h0; be_b = 4'h0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    idle();
  endtask

  // which: 3 = expect on both instances, 1 = only u0
  task automatic rd(input int port, input logic [3:0] addr, input logic [31:0] e0,
                    input logic [31:0] e1, input int which);
    exp_t e;
    if (port == 0) begin
      rd_en_a = 1'b1; addr_r_a = addr;
    end else begin
      rd_en_b = 1'b1; addr_r_b = addr;
    end
    if (which[0]) begin
      e.data = e0; e.due = cyc + 1; q[port].push_back(e);
    end
    if (which[1]) begin
      e.data = e1; e.due = cyc + 2; q[2 + port].push_back(e);
    end
  endtask

  task automatic wr(input int port, input logic [3:0] addr, input logic [31:0] d, input logic [3:0] be);
    if (port == 0) begin
      wr_en_a = 1'b1; addr_w_a = addr; data_a = d; be_a = be;
    end else begin
      wr_en_b = 1'b1; addr_w_b = addr; data_b = d; be_b = be;
    end
  endtask

  task automatic push_conf();
    qc[0].push_back(cyc + 1);
    qc[1].push_back(cyc + 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_data_a0", d_a0, 32'h0);
    chk("rst_data_b0", d_b0, 32'h0);
    chk("rst_data_a1", d_a1, 32'h0);
    chk("rst_data_b1", d_b1, 32'h0);
    chk("rst_valid", {28'h0, v_a0, v_b0, v_a1, v_b1}, 32'h0);
    chk("rst_conflict", {30'h0, conf0, conf1}, 32'h0);
    chk("rst_busy", {30'h0, busy0, busy1}, 32'h3);
  endtask

  // Watchdog: the run is a fixed sequence, so this only trips on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int cnt0, cnt1;
    for (int i = 0; i < 4; i++) last_d[i] = 32'h0;

    // Reset state
    rst = 1'b1;
    idle();
    step(); step(); step();
    chk_reset_outputs();
    hold_en = 1'b1;

    // Release reset; count busy cycles; accesses mid-init must be ignored
    rst = 1'b0;
    cnt0 = (busy0 === 1'b1) ? 1 : 0;
    cnt1 = (busy1 === 1'b1) ? 1 : 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (busy0 === 1'b1) cnt0++;
      if (busy1 === 1'b1) cnt1++;
      if (j == 7) begin
        #1;
        wr(0, 4'd3, 32'hDEAD_BEEF, 4'hF);
        wr(1, 4'd3, 32'h0BAD_F00D, 4'hF);
        rd_en_a = 1'b1; addr_r_a = 4'd3;
        rd_en_b = 1'b1; addr_r_b = 4'd2;
      end
      if (j == 8) begin
        #1;
        idle();
      end
    end
    #1;
    chk("init_busy_cycles_u0", cnt0, 32'd16);
    chk("init_busy_cycles_u1", cnt1, 32'd16);
    chk("busy_after_init", {30'h0, busy0, busy1}, 32'h0);

    // Read every address on both ports: all InitValue
    for (int a = 0; a < 16; a++) begin
      rd(0, a[3:0], IV, IV, 3);
      rd(1, 4'(15 - a), IV, IV, 3);
      step();
    end

    // Byte-enable merge; be=0 write leaves memory unchanged
    wr(0, 4'd3, 32'h1122_3344, 4'hF);
    wr(1, 4'd4, 32'hFFFF_FFFF, 4'h0);
    step();
    wr(0, 4'd3, 32'hAABB_CCDD, 4'b0101);
    step();
    rd(0, 4'd3, 32'h11BB_33DD, 32'h11BB_33DD, 3);
    rd(1, 4'd4, IV, IV, 3);
    step();

    // Same-address dual write with overlapping lanes
    wr(0, 4'd5, 32'h1234_5678, 4'hF);
    step();
    wr(0, 4'd5, 32'hFFFF_FFFF, 4'b0011);
    wr(1, 4'd5, 32'h0000_0000, 4'b0110);
    push_conf();
    step();
    rd(0, 4'd5, 32'h1200_FFFF, 32'h1200_FFFF, 3);
    step();

    // Same-address dual write, disjoint lanes: merged, no conflict
    wr(0, 4'd6, 32'h0000_0011, 4'b0001);
    wr(1, 4'd6, 32'h2200_0000, 4'b1000);
    step();
    rd(1, 4'd6, 32'h22A5_0F11, 32'h22A5_0F11, 3);
    step();

    // Read/write collision: old data (u0) vs forwarded data (u1)
    wr(0, 4'd7, 32'h0000_0001, 4'hF);
    step();
    wr(0, 4'd7, 32'h0000_0002, 4'hF);
    rd(1, 4'd7, 32'h0000_0001, 32'h0000_0002, 3);
    step();

    // Collision with dual-write merge forwarded
    wr(0, 4'd5, 32'h0000_00AA, 4'b0001);
    wr(1, 4'd5, 32'h0000_BBBB, 4'b0011);
    rd(0, 4'd5, 32'h1200_FFFF, 32'h1200_BBAA, 3);
    push_conf();
    step();

    // Collision where only port B writes
    wr(1, 4'd6, 32'h0000_3300, 4'b0010);
    rd(0, 4'd6, 32'h22A5_0F11, 32'h22A5_3311, 3);
    step();

    // Back-to-back reads, no bubbles
    rd(0, 4'd3, 32'h11BB_33DD, 32'h11BB_33DD, 3); rd(1, 4'd15, IV, IV, 3); step();
    rd(0, 4'd5, 32'h1200_BBAA, 32'h1200_BBAA, 3); rd(1, 4'd6, 32'h22A5_3311, 32'h22A5_3311, 3); step();
    rd(0, 4'd6, 32'h22A5_3311, 32'h22A5_3311, 3); step();
    rd(0, 4'd7, 32'h0000_0002, 32'h0000_0002, 3); step();
    step(); step(); step();

    // Reset with reads in flight: u1's pending read is dropped
    rd(0, 4'd3, 32'h11BB_33DD, 32'h11BB_33DD, 1);
    step();
    rst = 1'b1;
    rd_en_a = 1'b1; addr_r_a = 4'd5;
    for (int i = 0; i < 4; i++) last_d[i] = 32'h0;
    step();
    chk_reset_outputs();
    step();
    rst = 1'b0;
    for (int j = 0; j < 17; j++) step();
    chk("busy_after_reinit", {30'h0, busy0, busy1}, 32'h0);
    rd(0, 4'd3, IV, IV, 3);
    rd(1, 4'd7, IV, IV, 3);
    step();
    step(); step(); step();

    for (int i = 0; i < 4; i++) chk("rd_queue_empty", q[i].size(), 32'd0);
    chk("conf_queue_empty_u0", qc[0].size(), 32'd0);
    chk("conf_queue_empty_u1", qc[1].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
